// File: rtl/fetch_issue_stage.sv
// rtl/fetch_issue_stage.sv - fetch/issue front end of the accumulator processor
module fetch_issue_stage #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] ISR_ADDR    = 8'hF0,
    parameter logic [4:0] RETI_OPCODE = 5'b11111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        interrupt,
    output logic [7:0]  imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_rdata,
    output logic [4:0]  instr_out,
    output logic [2:0]  addrmode_out,
    output logic [7:0]  data_out,
    output logic [7:0]  pctr_out,
    output logic        issue_valid,
    output logic        first_stage_done,
    input  logic        exec_done,
    input  logic [7:0]  next_pctr,
    output logic [7:0]  int_ret_addr
);

    typedef enum logic [2:0] {OFF, FETCH, MEMWAIT, ISSUE, EXWAIT, INTENT} stateT;

    stateT      state;
    logic [7:0] pc;
    logic       intCur;
    logic       intPrev;
    logic       intPending;
    logic       intEn;
    logic       intEdge;
    logic       takeInt;

    assign intEdge = intCur & ~intPrev;
    // A retiring RETI never vectors straight back; pending requests wait for the next boundary.
    assign takeInt = (state == EXWAIT) && exec_done && intPending && intEn
                     && (instr_out != RETI_OPCODE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= OFF;
            pc               <= RESET_PC;
            intCur           <= 1'b0;
            intPrev          <= 1'b0;
            intPending       <= 1'b0;
            intEn            <= 1'b1;
            imem_addr        <= 8'h00;
            imem_rd          <= 1'b0;
            instr_out        <= 5'd0;
            addrmode_out     <= 3'd0;
            data_out         <= 8'h00;
            pctr_out         <= 8'h00;
            issue_valid      <= 1'b0;
            first_stage_done <= 1'b0;
            int_ret_addr     <= 8'h00;
        end else begin
            intCur  <= interrupt;
            intPrev <= intCur;
            // A new edge in the same cycle as the clear keeps the request alive.
            intPending <= (intPending & ~takeInt) | intEdge;

            unique case (state)
                OFF: begin
                    if (start) begin
                        pc        <= RESET_PC;
                        imem_addr <= RESET_PC;
                        imem_rd   <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    imem_rd <= 1'b0;
                    state   <= MEMWAIT;
                end
                MEMWAIT: begin
                    instr_out    <= imem_rdata[15:11];
                    addrmode_out <= imem_rdata[10:8];
                    data_out     <= imem_rdata[7:0];
                    pctr_out     <= pc;
                    issue_valid  <= 1'b1;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    issue_valid      <= 1'b0;
                    first_stage_done <= 1'b1;
                    state            <= EXWAIT;
                end
                EXWAIT: begin
                    if (exec_done) begin
                        first_stage_done <= 1'b0;
                        if (takeInt) begin
                            int_ret_addr <= next_pctr;
                            intEn        <= 1'b0;
                            state        <= INTENT;
                        end else begin
                            pc        <= next_pctr;
                            imem_addr <= next_pctr;
                            imem_rd   <= 1'b1;
                            state     <= FETCH;
                            if (instr_out == RETI_OPCODE) begin
                                intEn <= 1'b1;
                            end
                        end
                    end
                end
                INTENT: begin
                    pc        <= ISR_ADDR;
                    imem_addr <= ISR_ADDR;
                    imem_rd   <= 1'b1;
                    state     <= FETCH;
                end
                default: state <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_issue_stage.sv
// tb/tb_fetch_issue_stage.sv - scoreboard bench for fetch_issue_stage
module tb_fetch_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        interrupt;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_rdata;
    logic [4:0]  instr_out;
    logic [2:0]  addrmode_out;
    logic [7:0]  data_out;
    logic [7:0]  pctr_out;
    logic        issue_valid;
    logic        first_stage_done;
    logic        exec_done;
    logic [7:0]  next_pctr;
    logic [7:0]  int_ret_addr;

    fetch_issue_stage dut (
        .clk(clk), .reset(reset), .start(start), .interrupt(interrupt),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .addrmode_out(addrmode_out), .data_out(data_out),
        .pctr_out(pctr_out), .issue_valid(issue_valid),
        .first_stage_done(first_stage_done), .exec_done(exec_done),
        .next_pctr(next_pctr), .int_ret_addr(int_ret_addr)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr];

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int fetchCycle = 0;
    logic prevIv = 1'b0;
    logic [7:0] pcExp = 8'h00;
    logic [7:0] expFetch[$];
    logic [7:0] expIssue[$];
    logic [7:0] monPc;
    logic [15:0] monWord;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every fetch and issue must match what the driver queued.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_rd) begin
                if (expFetch.size() == 0) check("fetch_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
                else check("fetch_addr", 32'(imem_addr), 32'(expFetch.pop_front()));
                fetchCycle = cycle;
            end
            if (issue_valid) begin
                check("iv_pulse", 32'(prevIv), 32'd0);
                check("issue_latency", 32'(cycle - fetchCycle), 32'd2);
                if (expIssue.size() == 0) check("issue_unexpected", 32'(pctr_out), 32'hFFFF_FFFF);
                else begin
                    monPc   = expIssue.pop_front();
                    monWord = mem[monPc];
                    check("pctr", 32'(pctr_out), 32'(monPc));
                    check("instr", 32'(instr_out), 32'(monWord[15:11]));
                    check("addrmode", 32'(addrmode_out), 32'(monWord[10:8]));
                    check("data", 32'(data_out), 32'(monWord[7:0]));
                end
            end
        end
        prevIv = issue_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [7:0] a);
        expFetch.push_back(a);
        expIssue.push_back(a);
        pcExp = a;
    endtask

    task automatic wait_issue();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (issue_valid) seen = 1'b1;
        end
        check("issue_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd"}, 32'(imem_rd), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_fields"}, 32'({instr_out, addrmode_out, data_out}), 32'd0);
        check({tag, "_pctr"}, 32'(pctr_out), 32'd0);
        check({tag, "_flags"}, 32'({issue_valid, first_stage_done}), 32'd0);
        check({tag, "_ret"}, 32'(int_ret_addr), 32'd0);
    endtask

    task automatic start_run();
        expect_pc(8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_rd", 32'(imem_rd), 32'd1);
    endtask

    task automatic pulse_irq();
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        tick();
    endtask

    // Act as the execute stage for one instruction.
    task automatic step(input logic [7:0] n, input bit expInt, input int nIrq, input bit early);
        wait_issue();
        if (early) begin
            exec_done = 1'b1;
            next_pctr = 8'h55;
        end
        tick();
        exec_done = 1'b0;
        check("fsd_set", 32'(first_stage_done), 32'd1);
        for (int i = 0; i < nIrq; i++) pulse_irq();
        if (nIrq > 0 || early) begin
            tick();
            tick();
            check("hold_pctr", 32'(pctr_out), 32'(pcExp));
        end
        exec_done = 1'b1;
        next_pctr = n;
        expect_pc(expInt ? 8'hF0 : n);
        tick();
        exec_done = 1'b0;
        check("fsd_clear", 32'(first_stage_done), 32'd0);
        if (expInt) check("ret_addr", 32'(int_ret_addr), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = i[7:0];
            mem[i] = {1'b0, a[3:0], a[2:0] ^ 3'b101, ~a};
        end
        mem[8'h00] = 16'h8202;
        mem[8'hF2] = {5'b11111, 3'b000, 8'h00};

        reset = 1'b1; start = 1'b0; interrupt = 1'b0; exec_done = 1'b0; next_pctr = 8'h00;
        tick();
        tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        check("off_idle_rd", 32'(imem_rd), 32'd0);

        start_run();
        step(8'h01, 1'b0, 0, 1'b0);
        step(8'h02, 1'b0, 0, 1'b0);
        step(8'h03, 1'b0, 0, 1'b0);
        step(8'h04, 1'b0, 0, 1'b0);
        step(8'h05, 1'b0, 0, 1'b0);
        step(8'h06, 1'b1, 1, 1'b0);
        step(8'hF1, 1'b0, 2, 1'b0);
        step(8'hF2, 1'b0, 0, 1'b0);
        step(8'h06, 1'b0, 0, 1'b0);
        step(8'h07, 1'b1, 0, 1'b0);
        step(8'hF1, 1'b0, 0, 1'b0);
        step(8'hF2, 1'b0, 0, 1'b0);
        step(8'h07, 1'b0, 0, 1'b0);
        step(8'h08, 1'b0, 0, 1'b0);
        step(8'hFF, 1'b0, 0, 1'b1);
        step(8'h00, 1'b0, 0, 1'b0);

        wait_issue();
        tick();
        pulse_irq();
        tick();
        reset = 1'b1;
        tick();
        check_zero("rst_exwait");
        reset = 1'b0;
        expFetch.delete();
        expIssue.delete();
        tick();
        start_run();
        step(8'h01, 1'b0, 0, 1'b0);
        wait_issue();

        expFetch.push_back(8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_zero("rst_memwait");
        reset = 1'b0;
        expFetch.delete();
        expIssue.delete();
        tick();
        tick();
        check("post_rst_idle", 32'(issue_valid), 32'd0);
        start_run();
        step(8'h02, 1'b0, 0, 1'b0);
        wait_issue();
        tick();
        check("queues_drained", 32'(expFetch.size() + expIssue.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
